// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one registered N x N unsigned multiplier.
// Optional MULT_ARB_FIXED_PRIO_EN: requester 0 always wins ties (last grant still tracked).
module mult_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res_p,
  output logic           res_id
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             pid_q, pid_d;
  logic             vld_q, vld_d;
  logic [2*N-1:0]   prod;
  logic             gnt_v, gnt_id;

  always_comb begin
    gnt_v = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~last_q;
`endif
    end else begin
      gnt_id = req1_valid;
    end
  end

  // Shift-and-add array of partial products; settles during CALC.
  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (b_q[i]) prod = prod + ({{N{1'b0}}, a_q} << i);
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    last_d     = last_q;
    p_d        = p_q;
    pid_d      = pid_q;
    vld_d      = vld_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_v) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          a_d        = gnt_id ? req1_a : req0_a;
          b_d        = gnt_id ? req1_b : req0_b;
          id_d       = gnt_id;
          last_d     = gnt_id;
          state_d    = CALC;
        end
      end
      CALC: begin
        p_d     = prod;
        pid_d   = id_q;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      p_q     <= '0;
      pid_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      last_q  <= last_d;
      p_q     <= p_d;
      pid_q   <= pid_d;
      vld_q   <= vld_d;
    end
  end

  assign res_valid = vld_q;
  assign res_p     = p_q;
  assign res_id    = pid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level reference model plus directed scenarios.
module tb_mult_arbiter;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          res_valid, res_id;
  logic          res_ready = 1'b0;
  logic [2*N-1:0] res_p;

  int cmp = 0;
  int bad = 0;

  mult_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one job at a time; busy while computing or while a result waits.
  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      return 0;
`else
      return last ? 0 : 1;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  logic        m_calc, m_outv, m_last, m_pid, m_outid;
  int unsigned m_pa, m_pb;
  logic [15:0] m_outp;
  int          m_g;

  always_comb m_g = (m_calc || m_outv) ? -1 : pick(req0_valid, req1_valid, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_calc <= 1'b0; m_outv <= 1'b0; m_last <= 1'b1; m_pid <= 1'b0;
      m_outid <= 1'b0; m_outp <= '0; m_pa <= 0; m_pb <= 0;
    end else if (m_outv) begin
      if (res_ready) m_outv <= 1'b0;
    end else if (m_calc) begin
      m_calc  <= 1'b0;
      m_outv  <= 1'b1;
      m_outp  <= 16'(m_pa * m_pb);
      m_outid <= m_pid;
    end else if (m_g >= 0) begin
      m_calc <= 1'b1;
      m_last <= (m_g == 1);
      m_pid  <= (m_g == 1);
      m_pa   <= (m_g == 1) ? int'(req1_a) : int'(req0_a);
      m_pb   <= (m_g == 1) ? int'(req1_b) : int'(req0_b);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req0_ready", req0_ready, m_g == 0);
      chk("req1_ready", req1_ready, m_g == 1);
      chk("res_valid", res_valid, m_outv);
      if (m_outv) begin
        chk("res_p", res_p, m_outp);
        chk("res_id", res_id, m_outid);
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else         begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic wait_grant(input int id);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) break;
    end
    if (k == 20) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (k == 20) chk("result_timeout", 0, 1);
  endtask

  // Accept, one CALC cycle, one HOLD cycle drained by res_ready=1.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    res_ready = 1'b1;
    set_req(id, 1'b1, a, b);
    wait_grant(id);
    drive_slot();
    set_req(id, 1'b0, a, b);
    @(negedge clk); chk("lat_calc_valid", res_valid, 0);
    @(negedge clk); chk("lat_hold_valid", res_valid, 1);
    chk("op_p", res_p, p);
    chk("op_id", res_id, id);
    @(negedge clk); chk("drained_valid", res_valid, 0);
  endtask

  int          ids[$];
  logic [15:0] ps[$];

  initial begin
    #12;
    chk("rst_valid", res_valid, 0);
    chk("rst_p", res_p, 16'h0000);
    chk("rst_id", res_id, 0);
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);
    drive_slot(); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_valid", res_valid, 0);
    chk("idle_p", res_p, 16'h0000);

    drive_slot();
    run_op(0, 8'd13, 8'd11, 16'd143);
    drive_slot();
    run_op(1, 8'hFF, 8'hFF, 16'hFE01);
    drive_slot();
    run_op(1, 8'h00, 8'hA5, 16'h0000);

    // Contention: both requesters hold valid continuously.
    drive_slot();
    res_ready = 1'b1;
    set_req(0, 1'b1, 8'd3, 8'd5);
    set_req(1, 1'b1, 8'd7, 8'd9);
    for (int k = 0; k < 60 && ids.size() < 4; k++) begin
      @(negedge clk);
      if (res_valid) begin ids.push_back(int'(res_id)); ps.push_back(res_p); end
    end
    chk("rr_count", ids.size(), 4);
    drive_slot();
    set_req(0, 1'b0, 8'd0, 8'd0);
    set_req(1, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 4 && k < ids.size(); k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      chk("order_id", ids[k], 0);
      chk("order_p", ps[k], 16'd15);
`else
      chk("order_id", ids[k], k % 2);
      chk("order_p", ps[k], (k % 2) ? 16'd63 : 16'd15);
`endif
    end

    // Backpressure in HOLD with both requesters waiting.
    @(negedge clk);
    drive_slot();
    res_ready = 1'b0;
    set_req(0, 1'b1, 8'd2, 8'd3);
    set_req(1, 1'b1, 8'd4, 8'd5);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_p", res_p, 16'd6);
      chk("bp_id", res_id, 0);
      chk("bp_r0", req0_ready, 0);
      chk("bp_r1", req1_ready, 0);
    end
    drive_slot();
    res_ready = 1'b1;
    @(negedge clk); chk("bp_last_hold", res_valid, 1);
    drive_slot();
    @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
    chk("bp_next_r0", req0_ready, 1);
    chk("bp_next_r1", req1_ready, 0);
`else
    chk("bp_next_r0", req0_ready, 0);
    chk("bp_next_r1", req1_ready, 1);
`endif
    drive_slot();
    set_req(0, 1'b0, 8'd0, 8'd0);
    set_req(1, 1'b0, 8'd0, 8'd0);
    wait_valid();
`ifdef MULT_ARB_FIXED_PRIO_EN
    chk("bp_next_p", res_p, 16'd6);
    chk("bp_next_id", res_id, 0);
`else
    chk("bp_next_p", res_p, 16'd20);
    chk("bp_next_id", res_id, 1);
`endif

    // Asynchronous reset while the operation is in CALC.
    drive_slot();
    set_req(0, 1'b1, 8'd9, 8'd9);
    set_req(1, 1'b1, 8'd10, 8'd10);
    wait_grant(0);
    drive_slot();
    set_req(0, 1'b0, 8'd0, 8'd0);
    set_req(1, 1'b0, 8'd0, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_p", res_p, 16'h0000);
    chk("mid_rst_r0", req0_ready, 0);
    drive_slot(); #1 rst_n = 1'b1;
    set_req(0, 1'b1, 8'd9, 8'd9);
    set_req(1, 1'b1, 8'd10, 8'd10);
    @(negedge clk);
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    drive_slot();
    set_req(0, 1'b0, 8'd0, 8'd0);
    set_req(1, 1'b0, 8'd0, 8'd0);
    @(negedge clk); chk("post_rst_calc", res_valid, 0);
    @(negedge clk);
    chk("post_rst_res_v", res_valid, 1);
    chk("post_rst_res_p", res_p, 16'd81);
    chk("post_rst_res_id", res_id, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
